// File: rtl/ram_sp_initiator.sv
// Valid/ready command initiator that sequences cs/we/oe for a synchronous single-port RAM.
// Define RAM_INIT_WRITE_ACK_EN to return one acknowledgement beat per write burst.
module ram_sp_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_last,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  cs,
    output logic                  we,
    output logic                  oe
);

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_ISSUE,
        RD_ISSUE,
        RD_CAPTURE,
        RSP
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [LEN_WIDTH-1:0]    cnt_reg, cnt_next;
    logic                    is_write_reg, is_write_next;

    logic                    req_ready_reg;
    logic                    wready_reg;
    logic                    rsp_valid_reg;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
    logic                    rsp_last_reg;
    logic [ADDR_WIDTH-1:0]   address_reg;
    logic [DATA_WIDTH-1:0]   data_in_reg;
    logic                    cs_reg;
    logic                    we_reg;
    logic                    oe_reg;

    logic req_fire;
    logic w_fire;
    logic rsp_fire;
    logic issue_next;

    assign req_fire   = (state_reg == IDLE) && req_ready_reg && req_valid;
    assign w_fire     = (state_reg == WR_WAIT) && wready_reg && wvalid;
    assign rsp_fire   = (state_reg == RSP) && rsp_valid_reg && rsp_ready;
    assign issue_next = (state_next == WR_ISSUE) || (state_next == RD_ISSUE);

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        cnt_next      = cnt_reg;
        is_write_next = is_write_reg;
        case (state_reg)
            IDLE: begin
                if (req_fire) begin
                    addr_next     = req_addr;
                    cnt_next      = req_len;
                    is_write_next = req_we;
                    state_next    = req_we ? WR_WAIT : RD_ISSUE;
                end
            end
            WR_WAIT: begin
                if (w_fire) begin
                    state_next = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (cnt_reg == '0) begin
`ifdef RAM_INIT_WRITE_ACK_EN
                    state_next = RSP;
`else
                    state_next = IDLE;
`endif
                end else begin
                    addr_next  = addr_reg + ADDR_WIDTH'(1);
                    cnt_next   = cnt_reg - LEN_WIDTH'(1);
                    state_next = WR_WAIT;
                end
            end
            RD_ISSUE: begin
                state_next = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                state_next = RSP;
            end
            RSP: begin
                if (rsp_fire) begin
                    if ((cnt_reg == '0) || is_write_reg) begin
                        state_next = IDLE;
                    end else begin
                        addr_next  = addr_reg + ADDR_WIDTH'(1);
                        cnt_next   = cnt_reg - LEN_WIDTH'(1);
                        state_next = RD_ISSUE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Every output is registered from the next state so the RAM sees clean strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            cnt_reg       <= '0;
            is_write_reg  <= 1'b0;
            req_ready_reg <= 1'b0;
            wready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_last_reg  <= 1'b0;
            address_reg   <= '0;
            data_in_reg   <= '0;
            cs_reg        <= 1'b0;
            we_reg        <= 1'b0;
            oe_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            cnt_reg       <= cnt_next;
            is_write_reg  <= is_write_next;
            req_ready_reg <= (state_next == IDLE);
            wready_reg    <= (state_next == WR_WAIT);
            rsp_valid_reg <= (state_next == RSP);
            cs_reg        <= issue_next;
            we_reg        <= (state_next == WR_ISSUE);
            oe_reg        <= (state_next == RD_ISSUE);
            if (issue_next) begin
                address_reg <= addr_next;
            end
            if (w_fire) begin
                data_in_reg <= req_wdata;
            end
            if (state_reg == RD_CAPTURE) begin
                rsp_rdata_reg <= data_out;
                rsp_last_reg  <= (cnt_reg == '0);
            end else if ((state_reg == WR_ISSUE) && (state_next == RSP)) begin
                rsp_rdata_reg <= '0;
                rsp_last_reg  <= 1'b1;
            end
        end
    end

    assign req_ready = req_ready_reg;
    assign wready    = wready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_last  = rsp_last_reg;
    assign address   = address_reg;
    assign data_in   = data_in_reg;
    assign cs        = cs_reg;
    assign we        = we_reg;
    assign oe        = oe_reg;

endmodule

// File: tb/tb_ram_sp_initiator.sv
// Bench for ram_sp_initiator: behavioural RAM, shadow memory and a response scoreboard.
module tb_ram_sp_initiator;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic [DW-1:0] req_wdata;
    logic          wvalid, wready;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in, data_out;
    logic          cs, we, oe;

    ram_sp_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .wvalid(wvalid), .wready(wready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
        .address(address), .data_in(data_in), .data_out(data_out),
        .cs(cs), .we(we), .oe(oe)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram    [0:(1<<AW)-1];
    logic [DW-1:0] sb_mem [0:(1<<AW)-1];
    logic [DW-1:0] wbuf   [0:15];
    logic [DW:0]   exp_q[$];
    logic [DW:0]   got_q[$];
    logic [AW-1:0] we_addr_q[$];
    int            we_cnt = 0;
    int            cs_rsp_overlap = 0;
    int            we_oe_both = 0;
    int            n_vec = 0;
    int            n_err = 0;

    // Synchronous-read, synchronous-write RAM plus bus monitors.
    always @(posedge clk) begin
        if (cs && we) ram[address] <= data_in;
        if (cs && oe) data_out <= ram[address];
        if (!reset && rsp_valid && rsp_ready) got_q.push_back({rsp_last, rsp_rdata});
        if (cs && we) begin
            we_cnt <= we_cnt + 1;
            we_addr_q.push_back(address);
        end
        if (cs && rsp_valid) cs_rsp_overlap <= cs_rsp_overlap + 1;
        if (we && oe) we_oe_both <= we_oe_both + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        bit done = 0;
        req_valid = 1'b1; req_we = w; req_addr = a; req_len = l;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                @(negedge clk);
                done = 1;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL req_handshake: got timeout want req_ready");
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int n, input int stall_beat, input int stall_cycles);
        logic [AW-1:0] ad;
        bit done;
        send_req(1'b1, a, LW'(n - 1));
        for (int b = 0; b < n; b++) begin
            ad = a + AW'(b);
            sb_mem[ad] = wbuf[b];
            wvalid = 1'b1; req_wdata = wbuf[b];
            done = 0;
            for (int i = 0; i < 50; i++) begin
                if (wready) begin
                    @(negedge clk);
                    done = 1;
                    break;
                end
                @(negedge clk);
            end
            wvalid = 1'b0;
            if (!done) begin
                n_vec++; n_err++;
                $display("FAIL wbeat_handshake: got timeout want wready beat %0d", b);
            end
            if (b == stall_beat) repeat (stall_cycles) @(negedge clk);
        end
    endtask

    task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] l);
        logic [AW-1:0] ad;
        for (int i = 0; i <= int'(l); i++) begin
            ad = a + AW'(i);
            exp_q.push_back({(i == int'(l)), sb_mem[ad]});
        end
        send_req(1'b0, a, l);
        got_q.delete();
        for (int t = 0; t < 200 && got_q.size() < int'(l) + 1; t++) @(negedge clk);
    endtask

    task automatic test_reset;
        n_vec++;
        if ({req_ready, wready, rsp_valid, rsp_rdata, rsp_last, address, data_in, cs, we, oe} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b wrdy=%b rv=%b rd=%h rl=%b a=%h di=%h cs=%b we=%b oe=%b want all 0",
                     req_ready, wready, rsp_valid, rsp_rdata, rsp_last, address, data_in, cs, we, oe);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_single;
        int w0, n;
        logic [DW:0] e, g;
        wbuf[0] = 8'hA5;
        w0 = we_cnt;
        we_addr_q.delete();
        do_write(8'h10, 1, -1, 0);
        repeat (4) @(negedge clk);
        n_vec++;
        if (we_cnt - w0 != 1 || we_addr_q.size() != 1) begin
            n_err++;
            $display("FAIL single_we_count: got %0d want 1", we_cnt - w0);
        end else begin
            n_vec++;
            if (we_addr_q[0] !== 8'h10) begin
                n_err++;
                $display("FAIL single_we_addr: got %h want 10", we_addr_q[0]);
            end
        end
        exp_q.push_back({1'b1, 8'hA5});
        send_req(1'b0, 8'h10, 4'd0);
        got_q.delete();
        n_vec++;
        if ({cs, oe, we, address} !== {1'b1, 1'b1, 1'b0, 8'h10}) begin
            n_err++;
            $display("FAIL read_issue: got cs=%b oe=%b we=%b a=%h want cs=1 oe=1 we=0 a=10", cs, oe, we, address);
        end
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n != 2) begin
            n_err++;
            $display("FAIL read_latency: got %0d want 2 cycles", n);
        end
        for (int t = 0; t < 20 && got_q.size() < 1; t++) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL single_read: got last/data %h want %h", g, e);
            end
        end
    endtask

    task automatic test_wrap;
        logic [DW:0] e, g;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(8'hFE, 3, -1, 0);
        run_read(8'hFE, 4'd2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL wrap_beat%0d: got last/data %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [DW:0]   e, g;
        logic [DW-1:0] hold;
        int t;
        for (int i = 0; i < 2; i++) exp_q.push_back({(i == 1), sb_mem[8'hFF + AW'(i)]});
        rsp_ready = 1'b0;
        send_req(1'b0, 8'hFF, 4'd1);
        got_q.delete();
        for (t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
        hold = rsp_rdata;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, rsp_rdata, rsp_last, cs} !== {1'b1, hold, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b d=%h l=%b cs=%b want v=1 d=%h l=0 cs=0",
                         c, rsp_valid, rsp_rdata, rsp_last, cs, hold);
            end
        end
        rsp_ready = 1'b1;
        for (t = 0; t < 50 && got_q.size() < 2; t++) @(negedge clk);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL bp_beat%0d: got last/data %h want %h", i, g, e);
            end
        end
        n_vec++;
        if (cs_rsp_overlap != 0) begin
            n_err++;
            $display("FAIL cs_during_rsp: got %0d want 0", cs_rsp_overlap);
        end
    endtask

    task automatic test_write_stall;
        int w0;
        logic [DW:0] e, g;
        for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom_range(255));
        w0 = we_cnt;
        we_addr_q.delete();
        do_write(8'h40, 4, 1, 3);
        repeat (4) @(negedge clk);
        n_vec++;
        if (we_cnt - w0 != 4 || we_addr_q.size() != 4) begin
            n_err++;
            $display("FAIL stall_we_count: got %0d want 4", we_cnt - w0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (we_addr_q[i] !== 8'h40 + AW'(i)) begin
                    n_err++;
                    $display("FAIL stall_we_addr%0d: got %h want %h", i, we_addr_q[i], 8'h40 + AW'(i));
                end
            end
        end
        run_read(8'h40, 4'd3);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL stall_read%0d: got last/data %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [DW:0] e, g;
        int t;
        send_req(1'b0, 8'h00, 4'd7);
        got_q.delete();
        for (t = 0; t < 50 && got_q.size() < 1; t++) @(negedge clk);
        for (t = 0; t < 20 && !cs; t++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({req_ready, wready, rsp_valid, rsp_rdata, rsp_last, address, data_in, cs, we, oe} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got rdy=%b wrdy=%b rv=%b rd=%h rl=%b a=%h di=%h cs=%b we=%b oe=%b want all 0",
                     req_ready, wready, rsp_valid, rsp_rdata, rsp_last, address, data_in, cs, we, oe);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({cs, rsp_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL midreset_quiet%0d: got cs=%b rv=%b want 0 0", c, cs, rsp_valid);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        run_read(8'h10, 4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL post_reset_read: got last/data %h want %h", g, e);
            end
        end
    endtask

    task automatic test_write_ack;
        logic [DW:0] e, g;
        wbuf[0] = 8'h5A; wbuf[1] = 8'h6B;
        got_q.delete();
        do_write(8'h80, 2, -1, 0);
        repeat (6) @(negedge clk);
`ifdef RAM_INIT_WRITE_ACK_EN
        n_vec++;
        if (got_q.size() != 1) begin
            n_err++;
            $display("FAIL ack_count: got %0d want 1", got_q.size());
        end else begin
            n_vec++;
            if (got_q[0] !== {1'b1, 8'h00}) begin
                n_err++;
                $display("FAIL ack_beat: got last/data %h want 100", got_q[0]);
            end
        end
`else
        n_vec++;
        if (got_q.size() != 0) begin
            n_err++;
            $display("FAIL no_ack: got %0d responses want 0", got_q.size());
        end
`endif
        run_read(8'h80, 4'd1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL ack_readback%0d: got last/data %h want %h", i, g, e);
            end
        end
        n_vec++;
        if (we_oe_both != 0) begin
            n_err++;
            $display("FAIL we_oe_overlap: got %0d want 0", we_oe_both);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        req_wdata = '0; wvalid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = '0;
            sb_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset;
        test_single;
        test_wrap;
        test_backpressure;
        test_write_stall;
        test_reset_mid;
        test_write_ack;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
